pp_csa_reduce_ctrl: RTL
=======================

# pp_csa_reduce_ctrl

Sequential partial-product reduction controller for the Booth/Wallace multiplier datapath. Accepts a stream of partial products (already shifted and sign-extended to W bits) and folds them pairwise into a registered carry-save accumulator (sum row plus carry row), one shared 4:2 compression step at a time. Presents the final sum/carry pair to the hybrid final adder over a valid/ready handshake. Used when area matters more than the latency of a full Wallace tree.

## Interface
- `W`, 32: operand, accumulator and output width in bits.
- `MAX_PP`, 8: maximum beats per job, range 2..255.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: partial-product beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_data` input W: partial product.
- `in_last` input 1: marks the final beat of a job.
- `out_valid` output 1: result pair valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output W: carry-save sum row.
- `out_carry` output W: carry-save carry row, already weighted (shifted left).
- `out_beats` output 8: number of beats folded into the current result.
- `ovf` output 1: one-cycle pulse when a job is force-terminated at `MAX_PP`.
- `busy` output 1: high when the state is not ACCUM or the hold register is occupied.

## Operation
Compress step `cmp(w,x,y,z)`, all terms W bits, all results modulo 2^W:
- `t = w^x^y`
- `c1 = maj(w,x,y)<<1`
- `S = t^c1^z`
- `C = maj(t,c1,z)<<1`
- Invariant: `S+C ≡ w+x+y+z (mod 2^W)`.
- Bits shifted out of the MSB are discarded.

Registers: `acc_s`, `acc_c`, `p0`, `p1`, `hold` (p0 occupied), `lastf`, `cnt[7:0]`, state.

States and transitions:
- **ACCUM**: `in_ready=1`. A beat is accepted when `in_valid & in_ready`. On each accept, `cnt` increments and `force = (cnt+1 == MAX_PP)`.
  - `!hold & !in_last & !force`: `p0<=in_data`, `hold<=1`, stay in ACCUM.
  - `hold`: `p1<=in_data`, go to REDUCE.
  - `!hold & (in_last | force)`: `p0<=in_data`, `p1<=0`, go to REDUCE.
  - In both REDUCE cases: `lastf <= in_last | force`. `ovf` pulses next cycle if `force & !in_last`.
- **REDUCE**: `in_ready=0`. `{acc_s,acc_c} <= cmp(acc_s,acc_c,p0,p1)`, `hold<=0`. Next state is OUT if `lastf`, else ACCUM.
- **OUT**: `out_valid=1`, `out_sum=acc_s`, `out_carry=acc_c`, `out_beats=cnt`. On `out_ready`: clear `acc_s`, `acc_c`, `cnt`, `lastf`; go to ACCUM.

Output and boundary rules:
- `out_sum`, `out_carry`, `out_beats` are driven from the accumulator and counter continuously, but are meaningful only while `out_valid=1`.
- A beat arriving with `in_last` while `hold=1` is paired with `p0`; no zero operand is inserted.
- A job of exactly one beat yields `out_sum=in_data`, `out_carry=0`.
- After a forced termination, the next beat starts a new job.

## Timing
- Reset, asynchronous: state=ACCUM, all registers 0, `in_ready=1`, `out_valid=0`, `ovf=0`, `busy=0`, `out_sum=out_carry=0`, `out_beats=0`.
- Reset mid-job discards all partial state. The first beat after reset release starts a fresh job.
- Each pair costs 3 cycles: accept, accept, REDUCE. A lone final beat costs 2 cycles: accept, REDUCE.
- Latency from accept of the last beat to `out_valid=1` is 2 edges (REDUCE, then OUT).
- `out_valid` holds, and its data stays stable, until `out_ready` is high. `in_ready=0` throughout OUT.
- OUT→ACCUM takes one edge. A beat may be accepted in the cycle right after the output handshake.
- `in_valid` is ignored while `in_ready=0`; no beat is lost or double-counted.

## Test plan
- **Four beats**, `W=32`: 5, 7, 11, 13 with `in_last` on 13, `out_ready=1`.
  - Required: `out_sum+out_carry == 36`, `out_beats=4`.
  - Required: `out_valid` rises exactly 2 cycles after the last accept.
  - Required: `in_ready` low in both REDUCE cycles.
- **Single beat**: 0x00001234 with `in_last`.
  - Required: `out_sum=0x00001234`, `out_carry=0`, `out_beats=1`, `ovf=0`.
- **Odd count with wrap**: 0xFFFFFFFF, 1, 0x80000000 (last).
  - Required: `(out_sum+out_carry) mod 2^32 == 0x80000000`, `out_beats=3`.
- **Overflow**: `MAX_PP=8`, 10 beats of value 1, no `in_last`.
  - Required: first result has sum+carry=8, `out_beats=8`, and one `ovf` pulse.
  - Required: the remaining 2 beats form a second job that stays pending until `in_last`.
- **Backpressure**: hold `out_ready=0` for 5 cycles in OUT.
  - Required: `out_valid`, `out_sum`, `out_carry` stable; `in_ready=0`; beats offered meanwhile are not consumed.
- **Reset mid-job**: assert `rst` after 3 of 6 beats, then release.
  - Required: all outputs at reset values.
  - Required: a new 2-beat job of 100, 200 yields sum+carry=300, `out_beats=2`.

Source files
------------

// File: rtl/pp_csa_reduce_ctrl.sv
// pp_csa_reduce_ctrl
// Sequential partial-product reduction controller. Partial products arrive one
// beat at a time and are folded pairwise into a registered carry-save
// accumulator through a single shared 4:2 compression step. The finished
// sum/carry pair is handed to the final adder over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   partial-product beat handshake
//   in_data, in_last    partial product and end-of-job marker
//   out_valid/out_ready result handshake
//   out_sum, out_carry  carry-save result rows (carry already weighted)
//   out_beats           number of beats folded into the current result
//   ovf                 one-cycle pulse when a job is cut off at MAX_PP
//   busy                high unless idle in ACCUM with nothing held
module pp_csa_reduce_ctrl #(
  parameter int W      = 32,
  parameter int MAX_PP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [W-1:0] out_carry,
  output logic [7:0]   out_beats,
  output logic         ovf,
  output logic         busy
);

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] REDUCE = 2'd1;
  localparam logic [1:0] OUT    = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] accS_q, accS_d;
  logic [W-1:0] accC_q, accC_d;
  logic [W-1:0] p0_q, p0_d;
  logic [W-1:0] p1_q, p1_d;
  logic         hold_q, hold_d;
  logic         lastf_q, lastf_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  logic         accept;
  logic [7:0]   cntInc;
  logic         forceEnd;
  logic [W-1:0] cmpSum, cmpCarry;

  function automatic logic [W-1:0] maj(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic [W-1:0] c);
    maj = (a & b) | (a & c) | (b & c);
  endfunction

  // Two cascaded 3:2 stages form the 4:2 step; bits carried past the MSB
  // are dropped, so S+C matches the four-operand sum modulo 2^W.
  always_comb begin
    logic [W-1:0] t;
    logic [W-1:0] c1;
    t        = accS_q ^ accC_q ^ p0_q;
    c1       = maj(accS_q, accC_q, p0_q) << 1;
    cmpSum   = t ^ c1 ^ p1_q;
    cmpCarry = maj(t, c1, p1_q) << 1;
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign out_sum   = accS_q;
  assign out_carry = accC_q;
  assign out_beats = cnt_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != ACCUM) | hold_q;

  assign accept   = in_valid & in_ready;
  assign cntInc   = cnt_q + 8'd1;
  assign forceEnd = (cntInc == 8'(MAX_PP));

  // Next-state logic. A held beat is always paired with the incoming one,
  // even when that incoming beat ends the job; only a lone final beat gets
  // a zero partner.
  always_comb begin
    state_d = state_q;
    accS_d  = accS_q;
    accC_d  = accC_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    hold_d  = hold_q;
    lastf_d = lastf_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cntInc;
          if (hold_q) begin
            p1_d    = in_data;
            lastf_d = in_last | forceEnd;
            ovf_d   = forceEnd & ~in_last;
            state_d = REDUCE;
          end else if (in_last | forceEnd) begin
            p0_d    = in_data;
            p1_d    = '0;
            lastf_d = 1'b1;
            ovf_d   = forceEnd & ~in_last;
            state_d = REDUCE;
          end else begin
            p0_d   = in_data;
            hold_d = 1'b1;
          end
        end
      end
      REDUCE: begin
        accS_d  = cmpSum;
        accC_d  = cmpCarry;
        hold_d  = 1'b0;
        state_d = lastf_q ? OUT : ACCUM;
      end
      OUT: begin
        if (out_ready) begin
          accS_d  = '0;
          accC_d  = '0;
          cnt_d   = '0;
          lastf_d = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State registers; reset discards any partially folded job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      accS_q  <= '0;
      accC_q  <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      hold_q  <= 1'b0;
      lastf_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      accS_q  <= accS_d;
      accC_q  <= accC_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      hold_q  <= hold_d;
      lastf_q <= lastf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
